// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/DM backing-memory arbiter: FSM state encoding and
// backing access-size codes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2
  } arb_state_t;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t MEM_BYTE = 2'b00;
  localparam mem_size_t MEM_HALF = 2'b01;
  localparam mem_size_t MEM_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch
// and data access: fixed DM priority, bounded IF starvation, zero-latency return path.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [1:0]        dm_size,
  input  logic              dm_sign,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_sign,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  mem_size_t         size_q, size_d;
  logic              sign_q, sign_d;

  logic decide, if_cand, dm_cand, starved;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    sign_d   = sign_q;

    // The port completing this cycle still holds req high; it must not win again.
    decide  = (state_q == IDLE) || mem_ack;
    if_cand = if_req && !(mem_ack && state_q == SERVE_IF);
    dm_cand = dm_req && !(mem_ack && state_q == SERVE_DM);
    starved = (STARVE_LIMIT != 0) && (starve_q == LIMIT);

    if (decide) begin
      state_d = IDLE;
      if (if_cand && (!dm_cand || starved)) begin
        state_d  = SERVE_IF;
        starve_d = '0;
        we_d     = 1'b0;
        addr_d   = if_addr;
        wdata_d  = '0;
        size_d   = MEM_WORD;
        sign_d   = 1'b0;
      end else if (dm_cand) begin
        state_d = SERVE_DM;
        we_d    = dm_we;
        addr_d  = dm_addr;
        wdata_d = dm_wdata;
        size_d  = dm_size;
        sign_d  = dm_sign;
        if (if_cand && starve_q != LIMIT) begin
          starve_d = starve_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      starve_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= MEM_BYTE;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_size  = size_q;
  assign mem_sign  = sign_q;

  assign if_valid = mem_ack && (state_q == SERVE_IF);
  assign dm_valid = mem_ack && (state_q == SERVE_DM);
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign dm_rdata = dm_valid ? mem_rdata : '0;

  // A stray completion has no owner; it is dropped but worth flagging.
  always @(posedge CLK) begin
    if (RESET_N && state_q == IDLE) begin
      assert (!mem_ack) else $warning("mem_ack received while IDLE; ignored");
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// model of the arbitration rules (STARVE_LIMIT = 2).
module tb_mem_port_arbiter;

  localparam int LIM = 2;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        if_req, dm_req, dm_we, dm_sign, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [1:0]  dm_size;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, mem_req, mem_we, mem_sign, busy;
  logic [1:0]  mem_size;

  int total = 0;
  int bad   = 0;
  int if_vcnt = 0;
  int dm_vcnt = 0;

  // Model: owner 0 = none, 1 = IF, 2 = DM; plus the attributes of the granted transaction.
  int          owner  = 0;
  int          starve = 0;
  logic        x_we, x_sign;
  logic [31:0] x_addr, x_wdata;
  logic [1:0]  x_size;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_size(dm_size), .dm_sign(dm_sign), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_sign(mem_sign), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_next();
    bit acked, ifr, dmr;
    acked = (owner != 0) && mem_ack;
    ifr = if_req && !(acked && owner == 1);
    dmr = dm_req && !(acked && owner == 2);
    if (owner == 0 || acked) begin
      if (ifr && (!dmr || starve == LIM)) begin
        owner = 1; starve = 0;
        x_we = 0; x_addr = if_addr; x_wdata = 0; x_size = 2'b10; x_sign = 0;
      end else if (dmr) begin
        owner = 2;
        if (ifr) starve = (starve + 1 > LIM) ? LIM : starve + 1;
        x_we = dm_we; x_addr = dm_addr; x_wdata = dm_wdata; x_size = dm_size; x_sign = dm_sign;
      end else begin
        owner = 0;
      end
    end
  endtask

  // Called in the low clock phase with inputs already driven for this cycle.
  task automatic tick();
    #1;
    chk("mem_req", mem_req, owner != 0);
    chk("busy", busy, owner != 0);
    chk("if_valid", if_valid, owner == 1 && mem_ack);
    chk("dm_valid", dm_valid, owner == 2 && mem_ack);
    if (owner != 0) begin
      chk("mem_addr", mem_addr, x_addr);
      chk("mem_we", mem_we, x_we);
      chk("mem_size", mem_size, x_size);
      chk("mem_sign", mem_sign, x_sign);
      if (x_we) chk("mem_wdata", mem_wdata, x_wdata);
    end
    if (owner == 1 && mem_ack) chk("if_rdata", if_rdata, mem_rdata);
    if (owner == 2 && mem_ack && !x_we) chk("dm_rdata", dm_rdata, mem_rdata);
    if (if_valid) if_vcnt++;
    if (dm_valid) dm_vcnt++;
    $display("cyc t=%0t ifq=%b dmq=%b ack=%b req=%b addr=%h ifv=%b dmv=%b",
             $time, if_req, dm_req, mem_ack, mem_req, mem_addr, if_valid, dm_valid);
    model_next();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    if_req = 0; dm_req = 0; dm_we = 0; dm_sign = 0; mem_ack = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_size = 2'b10; mem_rdata = 0;
  endtask

  // One tie decided in IDLE, then the winner acks while the loser withdraws.
  task automatic starve_round(input logic [31:0] ia, input logic [31:0] da, input bit exp_if);
    if_req = 1; if_addr = ia; dm_req = 1; dm_we = 0; dm_addr = da; dm_size = 2'b10;
    tick();
    mem_ack = 1; mem_rdata = $urandom;
    if_req = exp_if; dm_req = !exp_if;
    #1;
    chk("t3_grant_addr", mem_addr, exp_if ? ia : da);
    tick();
    idle_inputs();
  endtask

  initial begin
    int ic, dc;
    idle_inputs();
    RESET_N = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_valids", {if_valid, dm_valid}, 0);
    @(negedge CLK);
    RESET_N = 1;
    owner = 0; starve = 0;
    tick();

    // 1: single fetch, ack three cycles after the grant
    if_req = 1; if_addr = 32'h100;
    tick();
    repeat (2) tick();
    mem_ack = 1; mem_rdata = 32'h00500093;
    #1;
    chk("t1_if_valid", if_valid, 1);
    chk("t1_if_rdata", if_rdata, 32'h00500093);
    chk("t1_mem_size", mem_size, 2'b10);
    tick();
    idle_inputs();
    tick();
    chk("t1_idle", busy, 0);

    // 2: simultaneous requests, DM first then straight into IF
    ic = if_vcnt; dc = dm_vcnt;
    if_req = 1; if_addr = 32'h104; dm_req = 1; dm_addr = 32'h2000;
    tick();
    #1 chk("t2_dm_first", mem_addr, 32'h2000);
    mem_ack = 1; mem_rdata = 32'hCAFE0001;
    tick();
    mem_ack = 0; dm_req = 0;
    #1 chk("t2_b2b_req", mem_req, 1);
    chk("t2_if_addr", mem_addr, 32'h104);
    tick();
    mem_ack = 1; mem_rdata = 32'h12345678;
    tick();
    idle_inputs();
    tick();
    chk("t2_if_count", if_vcnt - ic, 1);
    chk("t2_dm_count", dm_vcnt - dc, 1);

    // 3: starvation bound, grants DM, DM, IF, DM, DM, IF
    starve_round(32'h200, 32'h3000, 0);
    starve_round(32'h200, 32'h3004, 0);
    starve_round(32'h200, 32'h3008, 1);
    starve_round(32'h204, 32'h300C, 0);
    starve_round(32'h204, 32'h3010, 0);
    starve_round(32'h204, 32'h3014, 1);

    // 4: byte store
    ic = if_vcnt;
    dm_req = 1; dm_we = 1; dm_addr = 32'h11000000; dm_wdata = 32'hA5; dm_size = 2'b00;
    tick();
    tick();
    mem_ack = 1;
    #1;
    chk("t4_mem_we", mem_we, 1);
    chk("t4_mem_wdata", mem_wdata, 32'hA5);
    chk("t4_mem_size", mem_size, 2'b00);
    chk("t4_dm_valid", dm_valid, 1);
    tick();
    idle_inputs();
    tick();
    chk("t4_no_if_valid", if_vcnt - ic, 0);

    // 5: asynchronous reset two cycles into SERVE_DM
    dm_req = 1; dm_addr = 32'h4000;
    tick();
    tick();
    tick();
    RESET_N = 0; mem_ack = 1;
    #1;
    chk("t5_mem_req", mem_req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_dm_valid", dm_valid, 0);
    owner = 0; starve = 0;
    repeat (2) @(negedge CLK);
    idle_inputs();
    RESET_N = 1;
    tick();
    tick();
    chk("t5_idle", busy, 0);

    // 6: stray ack in IDLE
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t6_if_valid", if_valid, 0);
    chk("t6_dm_valid", dm_valid, 0);
    tick();
    mem_ack = 0;
    tick();
    chk("t6_still_idle", busy, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if_req  = ($urandom_range(0, 9) < 6);
      dm_req  = ($urandom_range(0, 9) < 6);
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      dm_we   = $urandom_range(0, 1); dm_sign = $urandom_range(0, 1);
      dm_size = 2'($urandom_range(0, 2));
      mem_rdata = $urandom;
      mem_ack = (owner != 0) && ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
